// File: rtl/core_inst_pkg.sv
// rtl/core_inst_pkg.sv - inst field positions, idle word and sequencer state type
package core_inst_pkg;

  localparam int ADDR_W = 11;
  localparam int INST_W = 34;

  localparam int B_ACC      = 33;
  localparam int B_CEN_P    = 32;
  localparam int B_WEN_P    = 31;
  localparam int B_AP_LO    = 20;
  localparam int B_CEN_X    = 19;
  localparam int B_WEN_X    = 18;
  localparam int B_AX_LO    = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXEC     = 1;
  localparam int B_LOAD     = 0;

  localparam logic [INST_W-1:0] INST_IDLE = 34'h1_800C_0000;

  typedef enum logic [2:0] {
    S_IDLE, S_W_FETCH, S_W_LOAD, S_W_SETTLE, S_X_FETCH, S_X_EXEC, S_DRAIN, S_DONE
  } state_e;

endpackage

// File: rtl/core_inst_seq_if.sv
// rtl/core_inst_seq_if.sv - controller/core-facing signals of the instruction sequencer
interface core_inst_seq_if;
  import core_inst_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] x_base;
  logic [ADDR_W-1:0] p_base;
  logic [6:0]        num_x;
  logic              acc_en;
  logic              l0_full;
  logic              l0_ready;
  logic              ofifo_valid;
  logic [INST_W-1:0] inst;
  logic              busy;
  logic              done;

  modport slave (
    input  start, w_base, x_base, p_base, num_x, acc_en, l0_full, l0_ready, ofifo_valid,
    output inst, busy, done
  );

  modport master (
    output start, w_base, x_base, p_base, num_x, acc_en, l0_full, l0_ready, ofifo_valid,
    input  inst, busy, done
  );

endinterface

// File: rtl/xmem_l0_fetch.sv
// rtl/xmem_l0_fetch.sv - XMEM read / L0 write pairing shared by kernel and activation fetch
module xmem_l0_fetch
  import core_inst_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              go_i,
  input  logic              en_i,
  input  logic              l0_full_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [6:0]        count_i,
  output logic              rd_o,
  output logic              l0_wr_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              fin_o
);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [6:0]        num_q, num_d, cnt_q, cnt_d, cnt_eff;
  logic              pend_q, pend_d, pend_eff;

  // go restarts the phase in the same cycle its first read is decided
  always_comb begin
    base_d   = go_i ? base_i  : base_q;
    num_d    = go_i ? count_i : num_q;
    cnt_eff  = go_i ? 7'd0    : cnt_q;
    pend_eff = go_i ? 1'b0    : pend_q;
    rd_o     = en_i && !l0_full_i && (cnt_eff < num_d);
    l0_wr_o  = en_i && !l0_full_i && pend_eff;
    addr_o   = base_d + ADDR_W'(cnt_eff);
    cnt_d    = en_i ? cnt_eff + {6'd0, rd_o} : cnt_q;
    pend_d   = en_i ? (l0_full_i ? pend_eff : rd_o) : pend_q;
  end

  assign fin_o = (cnt_q == num_q) && !pend_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q <= '0;
      num_q  <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      base_q <= base_d;
      num_q  <= num_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/core_inst_seq.sv
// rtl/core_inst_seq.sv - weight-stationary tile sequencer driving one core's inst bus
module core_inst_seq
  import core_inst_pkg::*;
#(
  parameter int ROW   = 8,
  parameter int COL   = 8,
  parameter int KWAIT = ROW + COL
) (
  input  logic          clk,
  input  logic          reset,
  core_inst_seq_if.slave bus
);

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d, cnt_eff;
  logic [ADDR_W-1:0] xb_q, pb_q;
  logic [6:0]        num_q;
  logic              acc_q, latch;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              busy_q, done_q;
  logic              f_go, f_en, f_rd, f_wr, f_fin, beat;
  logic [ADDR_W-1:0] f_base, f_addr;
  logic [6:0]        f_count;

  // state_q names the phase of the word currently on inst; state_d that of the next word
  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    f_go    = 1'b0;
    case (state_q)
      S_IDLE:     if (bus.start && bus.num_x != '0) begin
                    state_d = S_W_FETCH;
                    latch   = 1'b1;
                    f_go    = 1'b1;
                  end
      S_W_FETCH:  if (f_fin) state_d = S_W_LOAD;
      S_W_LOAD:   if (cnt_q == 16'(COL)) state_d = S_W_SETTLE;
      S_W_SETTLE: if (cnt_q == 16'(KWAIT)) begin
                    state_d = S_X_FETCH;
                    f_go    = 1'b1;
                  end
      S_X_FETCH:  if (f_fin) state_d = S_X_EXEC;
      S_X_EXEC:   if (cnt_q == {9'd0, num_q}) state_d = S_DRAIN;
      S_DRAIN:    if (cnt_q == {9'd0, num_q}) state_d = S_DONE;
      default:    state_d = S_IDLE;
    endcase
    f_en    = (state_d == S_W_FETCH) || (state_d == S_X_FETCH);
    f_base  = (state_q == S_IDLE) ? bus.w_base : xb_q;
    f_count = (state_q == S_IDLE) ? 7'(COL) : num_q;
  end

  xmem_l0_fetch u_fetch (
    .clk       (clk),
    .reset     (reset),
    .go_i      (f_go),
    .en_i      (f_en),
    .l0_full_i (bus.l0_full),
    .base_i    (f_base),
    .count_i   (f_count),
    .rd_o      (f_rd),
    .l0_wr_o   (f_wr),
    .addr_o    (f_addr),
    .fin_o     (f_fin)
  );

  always_comb begin
    cnt_eff = (state_d != state_q) ? 16'd0 : cnt_q;
    beat    = 1'b0;
    inst_d  = INST_IDLE;
    case (state_d)
      S_W_FETCH, S_X_FETCH: begin
        if (f_rd) begin
          inst_d[B_CEN_X]            = 1'b0;
          inst_d[B_WEN_X]            = 1'b1;
          inst_d[B_AX_LO +: ADDR_W]  = f_addr;
        end
        inst_d[B_L0_WR] = f_wr;
      end
      S_W_LOAD: if (bus.l0_ready) begin
        beat            = 1'b1;
        inst_d[B_L0_RD] = 1'b1;
        inst_d[B_LOAD]  = 1'b1;
      end
      S_W_SETTLE: beat = 1'b1;
      S_X_EXEC: if (bus.l0_ready) begin
        beat            = 1'b1;
        inst_d[B_L0_RD] = 1'b1;
        inst_d[B_EXEC]  = 1'b1;
      end
      S_DRAIN: if (bus.ofifo_valid) begin
        beat                      = 1'b1;
        inst_d[B_OFIFO_RD]        = 1'b1;
        inst_d[B_CEN_P]           = 1'b0;
        inst_d[B_WEN_P]           = 1'b0;
        inst_d[B_AP_LO +: ADDR_W] = pb_q + ADDR_W'(cnt_eff);
        inst_d[B_ACC]             = acc_q;
      end
      default: ;
    endcase
    cnt_d = cnt_eff + 16'(beat);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      xb_q    <= '0;
      pb_q    <= '0;
      num_q   <= '0;
      acc_q   <= 1'b0;
      inst_q  <= INST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inst_q  <= inst_d;
      busy_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q  <= (state_d == S_DONE);
      if (latch) begin
        xb_q  <= bus.x_base;
        pb_q  <= bus.p_base;
        num_q <= bus.num_x;
        acc_q <= bus.acc_en;
      end
    end
  end

  assign bus.inst = inst_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_core_inst_seq.sv
// tb/tb_core_inst_seq.sv - randomized self-checking bench for core_inst_seq
module tb_core_inst_seq;
  import core_inst_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  core_inst_seq_if bus ();

  core_inst_seq #(.ROW(8), .COL(8), .KWAIT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int full_pct = 0, rdy_stall = 0, vld_stall = 0, hold_left = 0;
  bit toggle_vld = 1'b0;
  bit pf, pr, pv;
  int tcyc = 0, t_start = 0, t_load = 0, w_wrs = 0, obs_busy = 0, obs_done = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic expect_cyc(input string tag, input logic [33:0] e, input bit b, input bit d);
    check_eq(tag, {28'd0, bus.inst, bus.busy, bus.done}, {28'd0, e, b, d});
  endtask

  // One clock: remember what the DUT sampled, then drive the next cycle's status bits
  task automatic adv();
    @(posedge clk);
    pf = bus.l0_full;
    pr = bus.l0_ready;
    pv = bus.ofifo_valid;
    #1;
    tcyc++;
    obs_busy += int'(bus.busy);
    obs_done += int'(bus.done);
    bus.start    = 1'b0;
    bus.l0_full  = (hold_left > 0) || ($urandom_range(0, 99) < full_pct);
    if (hold_left > 0) hold_left--;
    bus.l0_ready = $urandom_range(0, 99) >= rdy_stall;
    bus.ofifo_valid = toggle_vld ? ~bus.ofifo_valid : ($urandom_range(0, 99) >= vld_stall);
  endtask

  task automatic model_fetch(input string tag, input logic [10:0] base, input int n,
                             input int hold_at, output int wrs);
    int issued = 0;
    bit pend = 1'b0, rd, wr;
    logic [33:0] e;
    wrs = 0;
    while (issued < n || pend) begin
      adv();
      rd = !pf && (issued < n);
      wr = !pf && pend;
      e  = INST_IDLE;
      if (rd) begin
        e[19]   = 1'b0;
        e[17:7] = base + 11'(issued);
      end
      e[2] = wr;
      expect_cyc(tag, e, 1'b1, 1'b0);
      wrs += int'(bus.inst[2]);
      if (!pf) pend = rd;
      if (rd) begin
        issued++;
        if (issued == hold_at) hold_left = 3;
      end
    end
  endtask

  // kind: 0 kernel load, 1 execute, 2 drain, 3 settle
  task automatic model_beats(input string tag, input int kind, input int n, input logic [10:0] pb,
                             input bit acc, input int abort_at, output bit aborted);
    int k = 0;
    bit g;
    logic [33:0] e;
    aborted = 1'b0;
    while (k < n) begin
      adv();
      g = (kind == 2) ? pv : (kind == 3) ? 1'b1 : pr;
      e = INST_IDLE;
      if (g) begin
        case (kind)
          0: begin e[3] = 1'b1; e[0] = 1'b1; end
          1: begin e[3] = 1'b1; e[1] = 1'b1; end
          2: begin
            e[6] = 1'b1; e[32] = 1'b0; e[31] = 1'b0;
            e[30:20] = pb + 11'(k); e[33] = acc;
          end
          default: ;
        endcase
      end
      expect_cyc(tag, e, 1'b1, 1'b0);
      if (kind == 0 && g && t_load == 0) t_load = tcyc;
      if (g) k++;
      if (kind == 2 && k == abort_at) begin
        aborted = 1'b1;
        #2 reset = 1'b0;
        #1 expect_cyc("rst_mid_drain", INST_IDLE, 1'b0, 1'b0);
        repeat (2) begin
          @(negedge clk);
          check_eq("rst_no_done", 64'(bus.done), 64'd0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        return;
      end
    end
  endtask

  task automatic run_tile(input logic [10:0] wb, input logic [10:0] xb, input logic [10:0] pb,
                          input int nx, input bit acc, input int hold_at, input int abort_at,
                          output bit aborted);
    int dummy;
    obs_busy = 0; obs_done = 0; t_load = 0; t_start = tcyc;
    bus.start = 1'b1; bus.w_base = wb; bus.x_base = xb; bus.p_base = pb;
    bus.num_x = 7'(nx); bus.acc_en = acc;
    model_fetch("w_fetch", wb, 8, hold_at, w_wrs);
    bus.w_base = 11'($urandom); bus.x_base = 11'($urandom); bus.p_base = 11'($urandom);
    bus.num_x  = 7'($urandom);  bus.acc_en = 1'($urandom);
    model_beats("w_load", 0, 8, pb, acc, -1, aborted);
    bus.start = 1'b1;
    model_beats("w_settle", 3, 16, pb, acc, -1, aborted);
    model_fetch("x_fetch", xb, nx, 0, dummy);
    model_beats("x_exec", 1, nx, pb, acc, -1, aborted);
    model_beats("drain", 2, nx, pb, acc, abort_at, aborted);
    if (aborted) return;
    adv(); expect_cyc("done", INST_IDLE, 1'b0, 1'b1);
    adv(); expect_cyc("post_done", INST_IDLE, 1'b0, 1'b0);
  endtask

  initial begin
    bit ab;
    bus.start = 1'b0; bus.w_base = '0; bus.x_base = '0; bus.p_base = '0;
    bus.num_x = '0; bus.acc_en = 1'b0;
    bus.l0_full = 1'b0; bus.l0_ready = 1'b1; bus.ofifo_valid = 1'b1;

    #2 reset = 1'b0;
    #1 expect_cyc("reset_async", INST_IDLE, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b1;

    run_tile(11'd0, 11'd16, 11'd100, 4, 1'b1, 0, -1, ab);
    check_eq("nom_busy_len", 64'(obs_busy), 64'd46);
    check_eq("nom_done_cnt", 64'(obs_done), 64'd1);

    run_tile(11'd0, 11'd16, 11'd100, 4, 1'b0, 2, -1, ab);
    check_eq("bp_fetch_len", 64'(t_load - t_start - 1), 64'd12);
    check_eq("bp_l0_wr_cnt", 64'(w_wrs), 64'd8);

    toggle_vld = 1'b1;
    run_tile(11'd5, 11'd2046, 11'd2045, 4, 1'b1, 0, -1, ab);
    toggle_vld = 1'b0;

    full_pct = 20; rdy_stall = 25; vld_stall = 30;
    for (int i = 0; i < 6; i++)
      run_tile(11'($urandom), 11'($urandom), 11'($urandom), int'($urandom_range(1, 64)),
               1'($urandom), 0, -1, ab);
    full_pct = 0; rdy_stall = 0; vld_stall = 0;

    run_tile(11'd40, 11'd200, 11'd300, 6, 1'b1, 0, 2, ab);
    repeat (3) begin
      adv(); expect_cyc("after_abort_idle", INST_IDLE, 1'b0, 1'b0);
    end
    run_tile(11'd8, 11'd24, 11'd500, 5, 1'b0, 0, -1, ab);
    check_eq("rerun_busy_len", 64'(obs_busy), 64'd49);
    check_eq("rerun_done_cnt", 64'(obs_done), 64'd1);

    bus.num_x = 7'd0; bus.start = 1'b1;
    repeat (3) begin
      adv(); expect_cyc("zero_num_x", INST_IDLE, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
